// File: rtl/mmu_host.sv
// rtl/mmu_host.sv - byte-stream host that loads, launches and drains the 2x2 systolic multiplier
// Optional MMU_WATCHDOG_EN: abort WAIT after TIMEOUT cycles and set sticky err.
module mmu_host #(
  parameter int MMU_LAT = 3,
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] mmu_A [0:3],
  output logic [7:0] mmu_B [0:3],
  output logic       mmu_rst,
  input  logic [7:0] mmu_C [0:3],
  input  logic       mmu_done,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       err
);

  typedef enum logic [1:0] {LOAD, LAUNCH, WAIT, DRAIN} state_t;

`ifdef MMU_WATCHDOG_EN
  localparam int SAT = TIMEOUT;
`else
  localparam int SAT = MMU_LAT;
`endif
  localparam int CW = (SAT < 1) ? 1 : $clog2(SAT + 1);

  state_t        state, state_next;
  logic [2:0]    byte_cnt;
  logic [1:0]    out_cnt;
  logic [CW-1:0] wait_cnt;
  logic [7:0]    result [0:3];
  logic          err_q;
  logic          qual_done;
  logic          wd_abort;

  // The multiplier never clears done, so a 1 seen before MMU_LAT cycles may be stale.
  assign qual_done = (state == WAIT) && (wait_cnt >= CW'(MMU_LAT)) && mmu_done;

`ifdef MMU_WATCHDOG_EN
  assign wd_abort = (state == WAIT) && !qual_done && (wait_cnt == CW'(TIMEOUT));
`else
  assign wd_abort = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      LOAD:    if (in_valid && byte_cnt == 3'd7) state_next = LAUNCH;
      LAUNCH:  state_next = WAIT;
      WAIT: begin
        if (qual_done)     state_next = DRAIN;
        else if (wd_abort) state_next = LOAD;
      end
      DRAIN:   if (out_ready && out_cnt == 2'd3) state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= LOAD;
      byte_cnt <= '0;
      out_cnt  <= '0;
      wait_cnt <= '0;
      mmu_rst  <= 1'b1;
      err_q    <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        mmu_A[i]  <= '0;
        mmu_B[i]  <= '0;
        result[i] <= '0;
      end
    end else begin
      state   <= state_next;
      // Registered so the launch line is glitch-free; low exactly while in WAIT.
      mmu_rst <= (state_next != WAIT);

      if (state == LOAD && in_valid) begin
        byte_cnt <= byte_cnt + 3'd1;
        if (!byte_cnt[2]) mmu_A[byte_cnt[1:0]] <= in_data;
        else              mmu_B[byte_cnt[1:0]] <= in_data;
      end

      if (state != WAIT)           wait_cnt <= '0;
      else if (wait_cnt != CW'(SAT)) wait_cnt <= wait_cnt + CW'(1);

      if (qual_done) begin
        for (int i = 0; i < 4; i++) result[i] <= mmu_C[i];
      end

      if (state == DRAIN && out_ready) out_cnt <= out_cnt + 2'd1;

      if (wd_abort) err_q <= 1'b1;
    end
  end

  assign in_ready  = (state == LOAD);
  assign busy      = (state != LOAD);
  assign out_valid = (state == DRAIN);
  assign out_data  = result[out_cnt];
  assign err       = err_q;

endmodule

// File: tb/tb_mmu_host.sv
// tb/tb_mmu_host.sv - scoreboard bench for mmu_host with a multiplier stub
module tb_mmu_host;

  localparam int MMU_LAT = 3;
  localparam int TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] mmu_A [0:3];
  logic [7:0] mmu_B [0:3];
  logic       mmu_rst;
  logic [7:0] mmu_C [0:3];
  logic       mmu_done;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       err;

  int checks = 0;
  int failures = 0;

  // stub controls: mode 0 = done at wcnt==done_at, 1 = done stuck high, 2 = never
  int stub_mode = 0;
  int done_at = 3;
  bit stub_fixed = 1'b0;
  int wcnt = 0;
  int rdy_mode = 0;
  int xfers = 0;

  logic [7:0]  exp_q[$];
  logic [63:0] op_q[$];
  int          low_q[$];

  mmu_host #(.MMU_LAT(MMU_LAT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mmu_A(mmu_A), .mmu_B(mmu_B), .mmu_rst(mmu_rst),
    .mmu_C(mmu_C), .mmu_done(mmu_done),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mmu_rst) wcnt <= 0;
    else         wcnt <= wcnt + 1;
  end

  assign mmu_done = (stub_mode == 1) || (stub_mode == 0 && !mmu_rst && wcnt == done_at);

  always_comb begin
    for (int i = 0; i < 4; i++) mmu_C[i] = 8'h00;
    if (stub_fixed) begin
      mmu_C[0] = 8'h11; mmu_C[1] = 8'h22; mmu_C[2] = 8'h33; mmu_C[3] = 8'h44;
    end else begin
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < 2; c++)
          mmu_C[2*r+c] = mmu_A[2*r] * mmu_B[c] + mmu_A[2*r+1] * mmu_B[2+c];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] opbyte(input logic [63:0] ops, input int i);
    return ops[63-8*i -: 8];
  endfunction

  // Reference: row-major 2x2 product, each element reduced mod 256.
  function automatic logic [31:0] ref_mm(input logic [63:0] ops);
    int a[4], b[4], c[4];
    for (int i = 0; i < 4; i++) begin
      a[i] = int'(opbyte(ops, i));
      b[i] = int'(opbyte(ops, 4 + i));
    end
    c[0] = a[0]*b[0] + a[1]*b[2];
    c[1] = a[0]*b[1] + a[1]*b[3];
    c[2] = a[2]*b[0] + a[3]*b[2];
    c[3] = a[2]*b[1] + a[3]*b[3];
    return {c[0][7:0], c[1][7:0], c[2][7:0], c[3][7:0]};
  endfunction

  // out_ready driver
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // monitor / scoreboard
  int lowcnt = 0;
  bit prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  always @(negedge clk) begin
    if (!rst_n) begin
      lowcnt = 0;
      prev_stall = 1'b0;
    end else begin
      if (!mmu_rst) lowcnt++;
      else if (lowcnt != 0) begin
        if (low_q.size() == 0) check("rst_low_unexpected", 64'(lowcnt), 64'(0));
        else check("rst_low_len", 64'(lowcnt), 64'(low_q.pop_front()));
        lowcnt = 0;
      end
      if (busy && mmu_rst && !out_valid) begin
        if (op_q.size() == 0) check("launch_unexpected", 64'(1), 64'(0));
        else check("launch_AB", {mmu_A[0], mmu_A[1], mmu_A[2], mmu_A[3],
                                 mmu_B[0], mmu_B[1], mmu_B[2], mmu_B[3]}, op_q.pop_front());
      end
      if (out_valid) begin
        if (prev_stall) check("hold_data", 64'(out_data), 64'(prev_data));
        if (out_ready) begin
          if (exp_q.size() == 0) check("out_unexpected", 64'(out_data), 64'hFFFF);
          else check("out_data", 64'(out_data), 64'(exp_q.pop_front()));
          xfers++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic do_reset_checks(input string tag);
    check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    check({tag, "_mmu_rst"},   64'(mmu_rst),   64'(1));
    check({tag, "_in_ready"},  64'(in_ready),  64'(1));
    check({tag, "_busy"},      64'(busy),      64'(0));
    check({tag, "_out_data"},  64'(out_data),  64'(0));
  endtask

  // abort: 0 none, 1 reset after two result bytes, 2 done never arrives
  task automatic run_one(input logic [63:0] ops, input int mode, input int dat,
                         input bit fixed, input bit gaps, input bit junk, input int abort);
    logic [31:0] res;
    int idx, cyc, base;
    bit sent;
    stub_mode = mode; done_at = dat; stub_fixed = fixed;
    res = fixed ? 32'h11223344 : ref_mm(ops);
    if (abort != 2) begin
      for (int i = 0; i < 4; i++) exp_q.push_back(res[31-8*i -: 8]);
      low_q.push_back(mode == 1 ? MMU_LAT + 1 : dat + 1);
    end
`ifdef MMU_WATCHDOG_EN
    else low_q.push_back(TIMEOUT + 1);
`endif
    op_q.push_back(ops);
    base = xfers;
    idx = 0; cyc = 0;
    while (idx < 8 && cyc < 300) begin
      sent = !gaps || ($urandom_range(0, 2) == 0);
      in_valid = sent;
      in_data  = sent ? opbyte(ops, idx) : 8'hFF;
      @(posedge clk); #1;
      if (sent) idx++;
      cyc++;
    end
    if (idx < 8) check("load_timeout", 64'(idx), 64'(8));
    in_valid = junk;
    in_data  = 8'hFF;
    if (abort == 1) begin
      cyc = 0;
      while (xfers != base + 2 && cyc < 300) begin @(posedge clk); #1; cyc++; end
      check("abort_reach", 64'(xfers - base), 64'(2));
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      do_reset_checks("midreset");
      exp_q.delete();
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
    end else if (abort == 2) begin
`ifdef MMU_WATCHDOG_EN
      cyc = 0;
      do begin @(posedge clk); #1; cyc++; if (in_ready) in_valid = 1'b0; end
      while (busy && cyc < 100);
      check("wd_back_to_load", 64'(busy), 64'(0));
      check("wd_err", 64'(err), 64'(1));
`else
      repeat (120) @(posedge clk);
      #1;
      check("hang_busy", 64'(busy), 64'(1));
      check("hang_mmu_rst", 64'(mmu_rst), 64'(0));
      check("hang_err", 64'(err), 64'(0));
      in_valid = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
`endif
    end else begin
      cyc = 0;
      do begin @(posedge clk); #1; cyc++; end while (!in_ready && cyc < 400);
      in_valid = 1'b0;
      check("run_done", 64'(in_ready), 64'(1));
      check("all_drained", 64'(exp_q.size()), 64'(0));
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    do_reset_checks("reset");
    check("reset_err", 64'(err), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_one(64'h0102030405060708, 0, 3, 1'b1, 1'b0, 1'b0, 0);
    run_one({$urandom, $urandom}, 1, 3, 1'b0, 1'b0, 1'b0, 0);
    rdy_mode = 1;
    run_one(64'h0102030405060708, 0, 3, 1'b1, 1'b1, 1'b0, 0);
    rdy_mode = 0;
    run_one({$urandom, $urandom}, 0, 4, 1'b0, 1'b0, 1'b0, 1);
    run_one(64'h0807060504030201, 0, 3, 1'b0, 1'b0, 1'b0, 0);
    run_one({$urandom, $urandom}, 0, 5, 1'b0, 1'b0, 1'b1, 0);
    run_one({$urandom, $urandom}, 1, 3, 1'b0, 1'b1, 1'b1, 0);
    rdy_mode = 2;
    for (int r = 0; r < 20; r++)
      run_one({$urandom, $urandom}, $urandom_range(0, 1), $urandom_range(3, 6),
              1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    run_one({$urandom, $urandom}, 2, 3, 1'b0, 1'b0, 1'b1, 2);
    run_one({$urandom, $urandom}, 0, 3, 1'b0, 1'b1, 1'b0, 0);
`ifdef MMU_WATCHDOG_EN
    check("err_sticky", 64'(err), 64'(1));
`else
    check("err_tied", 64'(err), 64'(0));
`endif
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
